// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and sizing helpers for the serial add driver
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CARRY = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit counter width: ceil(log2(w)), never below one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-load right-shift register with serial LSB out
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = data_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sout = data_q[0];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial full adder with clearable carry register
module serial_adder #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic clear,
    output logic res
);

    if (W < 1) begin : g_invalid_width
    end

    logic carry_q;
    logic carry_d;

    always_comb begin
        carry_d = (a & b) | (a & carry_q) | (b & carry_q);
        if (clear) begin
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign res = a ^ b ^ carry_q;

endmodule

// File: rtl/serial_add_driver.sv
// rtl/serial_add_driver.sv - parallel front-end that drives a bit-serial adder
module serial_add_driver
    import serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_clear,
    input  logic         ser_res
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  res_q,   res_d;
    logic [W-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;

    logic accept;
    logic shift_en;
    logic a_bit;
    logic b_bit;

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign shift_en = (state_q == ST_SHIFT);

    piso_shift #(.W(W)) u_piso_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (in_a),
        .sout  (a_bit)
    );

    piso_shift #(.W(W)) u_piso_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (in_b),
        .sout  (b_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Result fills from the MSB end so bit 0 lands in place after W shifts.
                res_d        = res_q >> 1;
                res_d[W-1]   = ser_res;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CARRY;
                end
            end
            ST_CARRY: begin
                sum_d   = res_q;
                cout_d  = ser_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign ser_clear = (state_q == ST_CLEAR);
    assign ser_a     = shift_en & a_bit;
    assign ser_b     = shift_en & b_bit;

endmodule

// File: tb/tb_serial_add_driver.sv
// tb/tb_serial_add_driver.sv - self-checking bench for serial_add_driver with a serial_adder model
module tb_serial_add_driver;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         ser_a;
    logic         ser_b;
    logic         ser_clear;
    logic         ser_res;

    int checks;
    int errors;

    serial_add_driver #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_clear (ser_clear),
        .ser_res   (ser_res)
    );

    serial_adder #(.W(W)) u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ser_a),
        .b     (ser_b),
        .clear (ser_clear),
        .res   (ser_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers a,b, waits for accept, checks the serial stream, returns with out_valid seen at a negedge.
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] sum, output logic cout, output int lat);
        int n;
        int k;
        bit got;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (ser_clear !== 1'b1 || ser_a !== 1'b0 || ser_b !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle: clear=%b a=%b b=%b rdy=%b required 1 0 0 0",
                     ser_clear, ser_a, ser_b, in_ready);
        end
        k = 0;
        got = 0;
        while (!got && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k >= 1 && k <= W) begin
                checks++;
                if (ser_a !== a[k-1] || ser_b !== b[k-1] || ser_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_bit%0d: a=%b b=%b clear=%b required %b %b 0",
                             k - 1, ser_a, ser_b, ser_clear, a[k-1], b[k-1]);
                end
            end
            if (out_valid === 1'b1) got = 1;
        end
        if (!got) begin
            errors++;
            $display("FAIL out_valid_timeout: no out_valid within %0d cycles", k);
        end
        sum  = out_sum;
        cout = out_cout;
        lat  = k;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] sum, input logic cout);
        int total;
        total = int'(a) + int'(b);
        checks++;
        if ({cout, sum} !== (W+1)'(total)) begin
            errors++;
            $display("FAIL %s: got cout=%0d sum=%0d required cout=%0d sum=%0d",
                     name, cout, sum, total >> W, total % (1 << W));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
            ser_a !== 1'b0 || ser_b !== 1'b0 || ser_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%0d cout=%b sa=%b sb=%b clr=%b required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_cout, ser_a, ser_b, ser_clear);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] s;
        logic c;
        int lat;
        issue_and_wait(8'd7, 8'd3, s, c, lat);
        check_result("add_7_3", 8'd7, 8'd3, s, c);
        checks++;
        if (lat !== W + 2) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", lat, W + 2);
        end
        consume();
    endtask

    task automatic test_corners();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        logic [W-1:0] s;
        logic c;
        int lat;
        av[0] = 8'd200; bv[0] = 8'd100;
        av[1] = 8'd255; bv[1] = 8'd1;
        av[2] = 8'd0;   bv[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            issue_and_wait(av[i], bv[i], s, c, lat);
            check_result("corner", av[i], bv[i], s, c);
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic c;
        int lat;
        int hold;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            hold = $urandom_range(0, 3);
            issue_and_wait(a, b, s, c, lat);
            check_result("random", a, b, s, c);
            repeat (hold) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== s) begin
                errors++;
                $display("FAIL random_hold: vld=%b sum=%0d required 1 %0d", out_valid, out_sum, s);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic c;
        int lat;
        issue_and_wait(8'd5, 8'd9, s, c, lat);
        check_result("bp_5_9", 8'd5, 8'd9, s, c);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'd14 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b sum=%0d rdy=%b required 1 14 0",
                         i, out_valid, out_sum, in_ready);
            end
        end
        in_a = 8'd1;
        in_b = 8'd1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ser_clear !== 1'b0) begin
            errors++;
            $display("FAIL bp_done_valid: rdy=%b vld=%b clr=%b required 1 0 0",
                     in_ready, out_valid, ser_clear);
        end
        checks++;
        if (out_sum !== 8'd14 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_result_kept: sum=%0d cout=%b required 14 0", out_sum, out_cout);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic c;
        int lat;
        bit saw;
        @(negedge clk);
        in_a = 8'd100;
        in_b = 8'd27;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
            ser_a !== 1'b0 || ser_b !== 1'b0 || ser_clear !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy=%b vld=%b sum=%0d cout=%b sa=%b sb=%b clr=%b required 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_sum, out_cout, ser_a, ser_b, ser_clear);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL mid_reset_no_valid: out_valid seen 1 required 0");
        end
        issue_and_wait(8'd100, 8'd27, s, c, lat);
        check_result("after_reset_100_27", 8'd100, 8'd27, s, c);
        consume();
    endtask

    task automatic test_back_to_back();
        int acc_edge [$];
        logic [W:0] results [$];
        int e;
        @(negedge clk);
        in_a = 8'd12;
        in_b = 8'd34;
        in_valid = 1'b1;
        out_ready = 1'b1;
        e = 0;
        while (results.size() < 2 && e < 60) begin
            if (in_valid && in_ready) acc_edge.push_back(e + 1);
            if (out_valid && out_ready) results.push_back({out_cout, out_sum});
            @(posedge clk);
            e++;
            @(negedge clk);
            if (acc_edge.size() == 1) begin
                in_a = 8'd250;
                in_b = 8'd10;
            end else if (acc_edge.size() >= 2) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc_edge.size() != 2 || results.size() != 2) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d required 2 2",
                     acc_edge.size(), results.size());
        end else begin
            checks++;
            if (acc_edge[1] - acc_edge[0] != W + 4) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d required %0d", acc_edge[1] - acc_edge[0], W + 4);
            end
            checks++;
            if (results[0] !== 9'd46 || results[1] !== 9'd260) begin
                errors++;
                $display("FAIL b2b_results: got %0d,%0d required 46,260", results[0], results[1]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
